keypad_emulator: RTL and testbench

//  Synthesizable model of a 4x4 matrix keypad, the responder end of the keypad scanner.
//  It observes the scanner's column drive C and drives the row lines R as if one key were pressed.

---
 rtl/keypad_emulator.sv | 169 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder: answers scanner column drive on the
// row lines as if one key were held, with LFSR contact bounce.
module keypad_emulator #(
  parameter int          HOLD_CYCLES   = 200000,
  parameter int          BOUNCE_CYCLES = 2000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] key,
  input  logic [3:0] C,
  output logic [3:0] R,
  output logic       busy,
  output logic       done
);

  localparam int MAXC =
    (HOLD_CYCLES > BOUNCE_CYCLES) ?
    HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HLOAD =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BLOAD =
    (BOUNCE_CYCLES > 0) ?
    CW'(BOUNCE_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_B,
    HOLD,
    REL_B,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    key_q, key_d;
  logic [15:0]   lfsr;
  logic          bouncing;
  logic          contact;
  logic [1:0]    row_q, col_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      key_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      key_q <= key_d;
      busy  <= (state_d == PRESS_B) ||
               (state_d == HOLD) ||
               (state_d == REL_B);
      done  <= (state_d == DONE);
    end
  end

  // Each state loads its length minus one; leaving on zero.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    key_d   = key_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          key_d = key;
          if (BOUNCE_CYCLES == 0) begin
            state_d = HOLD;
            cnt_d   = HLOAD;
          end else begin
            state_d = PRESS_B;
            cnt_d   = BLOAD;
          end
        end
      end
      PRESS_B: begin
        if (cnt == '0) begin
          state_d = HOLD;
          cnt_d   = HLOAD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (BOUNCE_CYCLES == 0) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = REL_B;
            cnt_d   = BLOAD;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      REL_B: begin
        if (cnt == '0) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bouncing = (state == PRESS_B) ||
                    (state == REL_B);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else if (bouncing) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^
               lfsr[3] ^ lfsr[5],
               lfsr[15:1]};
    end
  end

  always_comb begin
    contact = 1'b0;
    if (state == HOLD) contact = 1'b1;
    else if (bouncing) contact = lfsr[0];
  end

  always_comb begin
    row_q = 2'd3;
    col_q = 2'd1;
    case (key_q)
      4'h1: begin row_q = 2'd0; col_q = 2'd0; end
      4'h2: begin row_q = 2'd0; col_q = 2'd1; end
      4'h3: begin row_q = 2'd0; col_q = 2'd2; end
      4'hA: begin row_q = 2'd0; col_q = 2'd3; end
      4'h4: begin row_q = 2'd1; col_q = 2'd0; end
      4'h5: begin row_q = 2'd1; col_q = 2'd1; end
      4'h6: begin row_q = 2'd1; col_q = 2'd2; end
      4'hB: begin row_q = 2'd1; col_q = 2'd3; end
      4'h7: begin row_q = 2'd2; col_q = 2'd0; end
      4'h8: begin row_q = 2'd2; col_q = 2'd1; end
      4'h9: begin row_q = 2'd2; col_q = 2'd2; end
      4'hC: begin row_q = 2'd2; col_q = 2'd3; end
      4'hE: begin row_q = 2'd3; col_q = 2'd0; end
      4'h0: begin row_q = 2'd3; col_q = 2'd1; end
      4'hF: begin row_q = 2'd3; col_q = 2'd2; end
      4'hD: begin row_q = 2'd3; col_q = 2'd3; end
      default: begin row_q = 2'd3; col_q = 2'd1; end
    endcase
  end

  // Zero-latency column-to-row path; only the key's column matters.
  always_comb begin
    R        = 4'hF;
    R[row_q] = ~(contact & ~C[col_q]);
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: bounce and no-bounce builds side by side,
// checked every cycle against a timeline model of the press sequence.
module tb_keypad_emulator;

  localparam int H = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] key = 4'h0;
  logic [3:0] c = 4'h0;
  logic [3:0] r_a, r_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int    n_vec = 0;
  int    n_err = 0;
  bit    rand_c = 1'b0;
  string phase = "init";

  int          mk   [2];
  logic [15:0] ml   [2];
  logic [3:0]  mkey [2];

  logic [3:0] keymap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD};
  int taps [4] = '{16, 14, 13, 11};

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES(H), .BOUNCE_CYCLES(5),
    .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .key(key), .C(c), .R(r_a),
    .busy(busy_a), .done(done_a));

  keypad_emulator #(
    .HOLD_CYCLES(H), .BOUNCE_CYCLES(0),
    .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .key(key), .C(c), .R(r_b),
    .busy(busy_b), .done(done_b));

  function automatic int bp(int d);
    return (d == 0) ? 5 : 0;
  endfunction

  function automatic int tot(int d);
    return 2 * bp(d) + H;
  endfunction

  function automatic logic in_bounce(int d);
    int k = mk[d];
    int b = bp(d);
    return (k >= 1 && k <= b) ||
           (k > b + H && k <= 2 * b + H);
  endfunction

  function automatic logic m_contact(int d);
    int k = mk[d];
    if (k > bp(d) && k <= bp(d) + H) return 1'b1;
    if (in_bounce(d)) return ml[d][0];
    return 1'b0;
  endfunction

  function automatic logic [15:0] lfsr_next(
    logic [15:0] l);
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= l[16 - taps[i]];
    return {fb, l[15:1]};
  endfunction

  function automatic logic [3:0] exp_r(int d);
    logic [3:0] r = 4'hF;
    int idx = 0;
    for (int i = 0; i < 16; i++)
      if (keymap[i] == mkey[d]) idx = i;
    if (m_contact(d) && !c[idx % 4])
      r[idx / 4] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mk[d]   = 0;
      ml[d]   = 16'hACE1;
      mkey[d] = 4'h0;
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (mk[d] == 0) begin
        if (start) begin
          mk[d]   = 1;
          mkey[d] = key;
        end
      end else begin
        if (in_bounce(d)) ml[d] = lfsr_next(ml[d]);
        mk[d]++;
        if (mk[d] > tot(d) + 1) mk[d] = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [3:0] o,
                     logic [3:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s/%s observed=%h expected=%h",
             phase, tag, o, e);
    end
  endtask

  task automatic check_r();
    chk("r_a", r_a, exp_r(0));
    chk("r_b", r_b, exp_r(1));
  endtask

  task automatic check_all();
    logic eb, ed;
    check_r();
    for (int d = 0; d < 2; d++) begin
      eb = (mk[d] >= 1 && mk[d] <= tot(d));
      ed = (mk[d] == tot(d) + 1);
      chk($sformatf("busy%0d", d),
          {3'b0, d == 0 ? busy_a : busy_b},
          {3'b0, eb});
      chk($sformatf("done%0d", d),
          {3'b0, d == 0 ? done_a : done_b},
          {3'b0, ed});
    end
    if (rand_c) begin
      c = 4'($urandom);
      #1;
      check_r();
    end
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #2;
      check_all();
    end
  endtask

  task automatic press(logic [3:0] k);
    key   = k;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    model_reset();

    phase = "reset";
    #1;
    check_all();
    #7;
    reset = 1'b1;
    tick(10);

    phase = "key5";
    rand_c = 1'b1;
    press(4'h5);
    tick(7);
    rand_c = 1'b0;
    c = 4'b1101;
    #1;
    chk("hold_col1", r_a, 4'b1101);
    check_r();
    c = 4'b1110;
    #1;
    chk("hold_col0", r_a, 4'hF);
    check_r();
    rand_c = 1'b1;
    tick(30);

    phase = "keyD";
    rand_c = 1'b0;
    c = 4'b0111;
    press(4'hD);
    tick(35);

    phase = "ignore";
    rand_c = 1'b1;
    press(4'hA);
    tick(10);
    press(4'h0);
    tick(18);
    press(4'h0);
    tick(40);

    phase = "midreset";
    press(4'(2 + $urandom_range(0, 13)));
    tick(14);
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    tick(3);
    reset = 1'b1;
    tick(2);
    press(4'h1);
    tick(35);

    phase = "key9";
    rand_c = 1'b0;
    c = 4'b1011;
    press(4'h9);
    tick(32);

    phase = "random";
    rand_c = 1'b1;
    for (int j = 0; j < 8; j++) begin
      press(4'($urandom));
      tick($urandom_range(3, 40));
    end
    tick(35);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
